// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the ram primitive family
package ram_pkg;

  typedef enum logic {
    RAM_IDLE  = 1'b0,
    RAM_CLEAR = 1'b1
  } ram_state_t;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int RAM_MAX_WIDTH = 1024;
  localparam int RAM_MAX_BE    = RAM_MAX_WIDTH / 8;

  function automatic logic [RAM_MAX_WIDTH-1:0] byte_merge(
    input logic [RAM_MAX_WIDTH-1:0] old_w,
    input logic [RAM_MAX_WIDTH-1:0] new_w,
    input logic [RAM_MAX_BE-1:0]    be
  );
    logic [RAM_MAX_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < RAM_MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  function automatic bit width_ok(input int w);
    return (w > 0) && (w % 8 == 0) && (w <= RAM_MAX_WIDTH);
  endfunction

  function automatic bit latency_ok(input int l);
    return (l == 1) || (l == 2);
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - post-reset sequencer that walks every word with a zero write
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int AW             = 12,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clock,
  input  logic          reset,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_busy
);

  ram_state_t    state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_IDLE;
      cnt_q   <= '0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        RAM_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          // Leave on the same edge that commits the write to the last word.
          if (cnt_q == '1) begin
            state_q <= RAM_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we    = busy_q;
  assign clr_addr  = cnt_q;
  assign init_busy = busy_q;

endmodule

// File: rtl/ram_dxwb_rrw_bypass.sv
// rtl/ram_dxwb_rrw_bypass.sv - byte-enabled dual-port RAM with port B write bypass and clear-on-reset
module ram_dxwb_rrw_bypass
  import ram_pkg::*;
#(
  parameter  int DEPTH          = 4096,
  parameter  int WIDTH          = 32,
  parameter  int LATENCY        = 1,
  parameter  int BYPASS         = 1,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int AW             = $clog2(DEPTH),
  localparam int BE             = WIDTH / 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    address_a,
  input  logic             wren_a,
  input  logic [BE-1:0]    byteena_a,
  input  logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] q_a,
  input  logic [AW-1:0]    address_b,
  output logic [WIDTH-1:0] q_b,
  output logic             init_busy
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("ram_dxwb_rrw_bypass: WIDTH must be a positive multiple of 8");
  end
  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("ram_dxwb_rrw_bypass: LATENCY must be 1 or 2");
  end
  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("ram_dxwb_rrw_bypass: DEPTH must be a power of two >= 2");
  end

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  ram_clear_seq #(
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clock     (clock),
    .reset     (reset),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_a;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [BE-1:0]    wr_be;
  logic             flush;

  assign wr_a  = wren_a && !init_busy && !reset;
  assign wr_en = !reset && (clr_we || wr_a);
  assign flush = reset || init_busy;

  // The clear sequencer owns the write port while it runs.
  always_comb begin
    wr_addr = address_a;
    wr_data = data_a;
    wr_be   = byteena_a;
    if (clr_we) begin
      wr_addr = clr_addr;
      wr_data = '0;
      wr_be   = '1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= WIDTH'(byte_merge(RAM_MAX_WIDTH'(mem[wr_addr]),
                                        RAM_MAX_WIDTH'(wr_data),
                                        RAM_MAX_BE'(wr_be)));
    end
  end

  logic [WIDTH-1:0] rd_a_raw;
  logic [WIDTH-1:0] rd_b_raw;
  logic [WIDTH-1:0] rd_b_next;
  logic             collide;

  assign rd_a_raw  = mem[address_a];
  assign rd_b_raw  = mem[address_b];
  assign collide   = (BYPASS != 0) && wr_a && (address_b == address_a);
  assign rd_b_next = collide ? WIDTH'(byte_merge(RAM_MAX_WIDTH'(rd_b_raw),
                                                 RAM_MAX_WIDTH'(data_a),
                                                 RAM_MAX_BE'(byteena_a)))
                             : rd_b_raw;

  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  always_ff @(posedge clock) begin
    if (flush) begin
      s1_a_q <= '0;
      s1_b_q <= '0;
    end else begin
      s1_a_q <= rd_a_raw;
      s1_b_q <= rd_b_next;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] s2_a_q;
    logic [WIDTH-1:0] s2_b_q;

    always_ff @(posedge clock) begin
      if (flush) begin
        s2_a_q <= '0;
        s2_b_q <= '0;
      end else begin
        s2_a_q <= s1_a_q;
        s2_b_q <= s1_b_q;
      end
    end

    assign q_a = s2_a_q;
    assign q_b = s2_b_q;
  end else begin : g_lat1
    assign q_a = s1_a_q;
    assign q_b = s1_b_q;
  end

endmodule

// File: doc/ram_dxwb_rrw_bypass.md
# ram_dxwb_rrw_bypass

Parametrised dual-port RAM with byte-enabled read/write port A and read-only port B. It adds selectable read latency (1 or 2), byte-granular read-during-write bypass onto port B, and an optional clear-on-reset sequencer that zeroes the array. It is the next-generation on-chip RAM primitive for the generic primitives library, used for register files, scratchpads and caches that need defined contents after reset.

## Interface
- DEPTH, 4096, number of words; power of two, >= 2.
- WIDTH, 32, word width in bits; multiple of 8, otherwise elaboration error.
- LATENCY, 1, read latency in cycles; 1 or 2, otherwise elaboration error.
- BYPASS, 1, 1 = port B sees same-cycle port A write data on collision; 0 = port B sees old data.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = no clear, contents undefined.
- Derived: AW = $clog2(DEPTH), BE = WIDTH/8.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- address_a  in  AW  port A word address.
- wren_a  in  1  port A write strobe.
- byteena_a  in  BE  byte enables; bit i covers data bits 8i+7:8i.
- data_a  in  WIDTH  port A write data.
- q_a  out  WIDTH  port A read data.
- address_b  in  AW  port B word address.
- q_b  out  WIDTH  port B read data.
- init_busy  out  1  high while reset is asserted or the clear sequence runs, when CLEAR_ON_RESET = 1.

## Operation
- State machine with two states, IDLE and CLEAR.
  - In reset: state goes to CLEAR if CLEAR_ON_RESET = 1, else IDLE. The clear counter goes to 0.
  - CLEAR: writes 0 to mem[counter] every cycle and increments the counter. After the write to DEPTH-1 it goes to IDLE, so the sequence takes exactly DEPTH cycles.
  - Reset asserted mid-clear restarts the sequence at address 0.
- During reset and CLEAR:
  - Port A writes are ignored.
  - q_a and q_b are forced to 0, including any values already in the pipeline registers.
- Port A write (IDLE, wren_a = 1): only bytes with byteena_a[i] = 1 are updated. wren_a = 1 with byteena_a = 0 changes nothing.
- Port A read is read-first: on a write cycle, q_a returns the contents before the write.
- Port B collision (address_b == address_a, wren_a = 1, IDLE):
  - BYPASS = 1: q_b returns the merged word, i.e. enabled bytes from data_a and the other bytes from the old contents.
  - BYPASS = 0: q_b returns the old contents.
- Both ports may read the same address in the same cycle; both return identical data.
- Addresses are never out of range, because AW matches DEPTH exactly.

## Timing
- Reset value of every output:
  - q_a = 0 and q_b = 0.
  - init_busy = 1 if CLEAR_ON_RESET = 1, else 0.
- init_busy timing with CLEAR_ON_RESET = 1: init_busy falls on the rising edge after the last clear write. That is DEPTH cycles after the first edge with reset low.
- Read latency:
  - LATENCY = 1: q reflects the address presented at edge N, valid after edge N+1.
  - LATENCY = 2: one extra output register; valid after edge N+2.
- Read latency is identical on both ports and constant, with no stalls.
- A write at edge N is visible to a normal (non-bypass) read whose address is presented at edge N+1 or later.
- The bypass merge is applied in the first read stage. With LATENCY = 2 the merged word therefore appears one cycle later, same as normal reads.

## Structure
- Shared package ram_pkg:
  - ram_state_t enum {RAM_IDLE, RAM_CLEAR}.
  - Function byte_merge(old, new, be), used for both the array write and the port B bypass.
  - Elaboration-check helpers for the WIDTH and LATENCY constraints.
- One sub-module, ram_clear_seq:
  - Contains the FSM and the AW-bit counter.
  - Outputs clr_we, clr_addr and init_busy.
  - The top muxes clr_we/clr_addr over port A while the sequencer is busy.
- Memory array is a plain reg array with per-byte write, inferable as block RAM. Output registers are the only reset flops on the data path.

## Test plan
- Clear on reset (DEPTH=16, CLEAR_ON_RESET=1): hold reset 3 cycles, release.
  - init_busy stays 1 for exactly 16 cycles after release.
  - Then reads of addresses 0..15 return 0 on both ports.
  - A write attempted during clear has no effect.
- Byte-enable write (WIDTH=32, LATENCY=1): write 0xAABBCCDD, be=4'b1111 to addr 5; then 0x11223344, be=4'b0101 to addr 5.
  - Read of addr 5 returns 0xAA22CC44 one cycle after the address.
- Port B bypass: mem[7] = 0x00000000; write 0xDEADBEEF, be=4'b0011 to addr 7 with address_b = 7 in the same cycle.
  - BYPASS=1: q_b = 0x0000BEEF and q_a = 0x00000000.
  - BYPASS=0: q_b = 0x00000000.
- Latency 2: back-to-back reads of addresses 1, 2, 3 holding 0x1, 0x2, 0x3.
  - q_b shows 0x1, 0x2, 0x3 on consecutive cycles, starting two edges after address 1.
- Reset mid-clear (DEPTH=16): assert reset at clear count 9 for 1 cycle.
  - Counter restarts at 0.
  - init_busy stays high for 16 more cycles after release.
  - q_a and q_b read 0 throughout.
- No-op write: wren_a = 1 with byteena_a = 0 to addr 3 holding 0x12345678.
  - Subsequent read returns 0x12345678.
